// File: rtl/video_timing_detect.sv
// -----------------------------------------------------------------------------
// video_timing_detect
//   Receive-side video timing analyser. Registers incoming DE/HS/VS, measures
//   horizontal and vertical timing per frame, and declares lock once two
//   consecutive good frames carry identical timing. Also produces active-area
//   pixel coordinates aligned with a two-clock delayed copy of DE.
//
// Parameters
//   CW       width of all timing counters and measurement outputs
//   TIMEOUT  pixel clocks without an HS rising edge before lock is dropped
//
// Ports
//   I_pxl_clk      pixel clock (sole clock)
//   I_rst          synchronous reset, active-high
//   I_de/I_hs/I_vs incoming video timing, active-high
//   O_h_*          measured h total / sync / back porch / resolution
//   O_v_*          measured v total / sync / back porch / resolution
//   O_meas_valid   one-cycle pulse when the measurement outputs update
//   O_locked       timing identical over two consecutive good frames
//   O_de/O_x/O_y   delayed DE with active column/row coordinates
// -----------------------------------------------------------------------------
module video_timing_detect #(
  parameter int CW      = 12,
  parameter int TIMEOUT = 4096
) (
  input  logic          I_pxl_clk,
  input  logic          I_rst,
  input  logic          I_de,
  input  logic          I_hs,
  input  logic          I_vs,
  output logic [CW-1:0] O_h_total,
  output logic [CW-1:0] O_h_sync,
  output logic [CW-1:0] O_h_bporch,
  output logic [CW-1:0] O_h_res,
  output logic [CW-1:0] O_v_total,
  output logic [CW-1:0] O_v_sync,
  output logic [CW-1:0] O_v_bporch,
  output logic [CW-1:0] O_v_res,
  output logic          O_meas_valid,
  output logic          O_locked,
  output logic          O_de,
  output logic [CW-1:0] O_x,
  output logic [CW-1:0] O_y
);

  localparam logic [CW-1:0] MAX = '1;
  localparam int            TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_FIRST, ST_TRACK} state_t;

  typedef struct packed {
    logic [CW-1:0] h_total;
    logic [CW-1:0] h_sync;
    logic [CW-1:0] h_bporch;
    logic [CW-1:0] h_res;
    logic [CW-1:0] v_total;
    logic [CW-1:0] v_sync;
    logic [CW-1:0] v_bporch;
    logic [CW-1:0] v_res;
  } meas_t;

  // Input stage and edge history
  logic r_de, r_hs, r_vs, r_de_d, r_hs_d, r_vs_hs;
  // Current-line accumulators (position p of the registered sample)
  logic [CW-1:0] r_p, r_l_sync, r_l_dep, r_l_res;
  logic          r_l_sync_seen, r_l_de_seen, r_l_vs;
  // Current-frame accumulators; h reference is taken from the first line seen
  logic [CW-1:0] r_f_ht, r_f_hs, r_f_hbp, r_f_hr;
  logic [CW-1:0] r_f_vt, r_f_vs, r_f_vbp, r_f_vr;
  logic          r_f_ht_set, r_f_hd_set, r_f_de_seen, r_f_bad;
  // Control and reported values
  state_t        r_state;
  logic [TW-1:0] r_to;
  logic [CW-1:0] r_row;
  meas_t         r_meas;

  logic          w_hs_rise, w_frame_start, w_line_bad, w_bp_line, w_fin_bad;
  logic [CW-1:0] w_p, w_lt, w_lbp;
  meas_t         w_fin;

  assign w_hs_rise     = r_hs & ~r_hs_d;
  // Frame start: first line start with VS high after a line start with VS low
  assign w_frame_start = w_hs_rise & r_vs & ~r_vs_hs;
  assign w_p           = w_hs_rise ? '0 : ((r_p == MAX) ? MAX : r_p + CW'(1));

  // Contribution of the line that closes on this HS rising sample.
  // NOTE: every combinational output gets a default first so no latch can form.
  always_comb begin
    w_lt       = r_p + CW'(1);
    w_lbp      = r_l_dep - r_l_sync;
    w_line_bad = (r_f_ht_set && (w_lt != r_f_ht)) ||
                 (r_l_de_seen && r_f_hd_set &&
                  ((r_l_sync != r_f_hs) || (w_lbp != r_f_hbp) || (r_l_res != r_f_hr)));
    w_bp_line  = ~r_l_de_seen & ~r_l_vs & ~r_f_de_seen;
    w_fin_bad  = r_f_bad | w_line_bad;

    w_fin.h_total  = r_f_ht_set ? r_f_ht  : w_lt;
    w_fin.h_sync   = r_f_hd_set ? r_f_hs  : (r_l_de_seen ? r_l_sync : '0);
    w_fin.h_bporch = r_f_hd_set ? r_f_hbp : (r_l_de_seen ? w_lbp    : '0);
    w_fin.h_res    = r_f_hd_set ? r_f_hr  : (r_l_de_seen ? r_l_res  : '0);
    w_fin.v_total  = r_f_vt;
    w_fin.v_sync   = r_f_vs;
    w_fin.v_bporch = r_f_vbp + {{(CW-1){1'b0}}, w_bp_line};
    w_fin.v_res    = r_f_vr  + {{(CW-1){1'b0}}, r_l_de_seen};
  end

  // Input registers, edge history and active-area coordinates.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      r_de <= 1'b0; r_hs <= 1'b0; r_vs <= 1'b0;
      r_de_d <= 1'b0; r_hs_d <= 1'b0; r_vs_hs <= 1'b0;
      r_row <= '0; O_de <= 1'b0; O_x <= '0; O_y <= '0;
    end else begin
      r_de   <= I_de;
      r_hs   <= I_hs;
      r_vs   <= I_vs;
      r_de_d <= r_de;
      r_hs_d <= r_hs;
      if (w_hs_rise) begin
        r_vs_hs <= r_vs;
        if (w_frame_start)    r_row <= '0;
        else if (r_l_de_seen) r_row <= r_row + CW'(1);
      end
      O_de <= r_de;
      O_x  <= (r_de && r_de_d) ? O_x + CW'(1) : '0;
      O_y  <= r_row;
    end
  end

  // Line and frame measurement accumulators
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      r_p <= '0; r_l_sync <= '0; r_l_dep <= '0; r_l_res <= '0;
      r_l_sync_seen <= 1'b0; r_l_de_seen <= 1'b0; r_l_vs <= 1'b0;
      r_f_ht <= '0; r_f_hs <= '0; r_f_hbp <= '0; r_f_hr <= '0;
      r_f_vt <= '0; r_f_vs <= '0; r_f_vbp <= '0; r_f_vr <= '0;
      r_f_ht_set <= 1'b0; r_f_hd_set <= 1'b0; r_f_de_seen <= 1'b0; r_f_bad <= 1'b0;
    end else begin
      r_p <= w_p;
      if (w_hs_rise) begin
        // The rising sample itself is p=0 of the new line
        r_l_sync_seen <= 1'b0;
        r_l_sync      <= '0;
        r_l_dep       <= '0;
        r_l_de_seen   <= r_de;
        r_l_res       <= {{(CW-1){1'b0}}, r_de};
        r_l_vs        <= r_vs;
        if (w_frame_start) begin
          r_f_ht_set <= 1'b0; r_f_hd_set <= 1'b0; r_f_de_seen <= 1'b0; r_f_bad <= 1'b0;
          r_f_ht <= '0; r_f_hs <= '0; r_f_hbp <= '0; r_f_hr <= '0;
          r_f_vt <= CW'(1); r_f_vs <= CW'(1); r_f_vbp <= '0; r_f_vr <= '0;
        end else begin
          if (!r_f_ht_set) begin
            r_f_ht     <= w_lt;
            r_f_ht_set <= 1'b1;
          end
          if (r_l_de_seen && !r_f_hd_set) begin
            r_f_hs     <= r_l_sync;
            r_f_hbp    <= w_lbp;
            r_f_hr     <= r_l_res;
            r_f_hd_set <= 1'b1;
          end
          if (r_l_de_seen) begin
            r_f_vr      <= r_f_vr + CW'(1);
            r_f_de_seen <= 1'b1;
          end
          if (w_bp_line)          r_f_vbp <= r_f_vbp + CW'(1);
          if (r_vs)               r_f_vs  <= r_f_vs + CW'(1);
          if (r_f_vt != MAX)      r_f_vt  <= r_f_vt + CW'(1);
          if (w_line_bad || r_f_vt == MAX) r_f_bad <= 1'b1;
        end
      end else begin
        if (r_p == MAX) r_f_bad <= 1'b1;
        if (!r_hs && !r_l_sync_seen) begin
          r_l_sync      <= w_p;
          r_l_sync_seen <= 1'b1;
        end
        if (r_de) begin
          if (!r_l_de_seen) begin
            r_l_dep     <= w_p;
            r_l_de_seen <= 1'b1;
          end
          if (r_l_res != MAX) r_l_res <= r_l_res + CW'(1);
        end
      end
    end
  end

  // Lock FSM with registered measurement, valid and lock outputs
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      r_state      <= ST_SEARCH;
      r_to         <= '0;
      r_meas       <= '0;
      O_meas_valid <= 1'b0;
      O_locked     <= 1'b0;
    end else begin
      O_meas_valid <= 1'b0;
      if (w_hs_rise)                 r_to <= '0;
      else if (r_to != TW'(TIMEOUT)) r_to <= r_to + TW'(1);

      if (!w_hs_rise && r_to == TW'(TIMEOUT - 1)) begin
        O_locked <= 1'b0;
        r_state  <= ST_SEARCH;
      end else if (w_frame_start) begin
        unique case (r_state)
          ST_SEARCH: r_state <= ST_FIRST;
          ST_FIRST: begin
            if (!w_fin_bad) begin
              r_meas       <= w_fin;
              O_meas_valid <= 1'b1;
              r_state      <= ST_TRACK;
            end
          end
          ST_TRACK: begin
            if (!w_fin_bad) begin
              r_meas       <= w_fin;
              O_meas_valid <= 1'b1;
              O_locked     <= (w_fin == r_meas);
            end else begin
              O_locked <= 1'b0;
              r_state  <= ST_FIRST;
            end
          end
          default: r_state <= ST_SEARCH;
        endcase
      end
    end
  end

  assign O_h_total  = r_meas.h_total;
  assign O_h_sync   = r_meas.h_sync;
  assign O_h_bporch = r_meas.h_bporch;
  assign O_h_res    = r_meas.h_res;
  assign O_v_total  = r_meas.v_total;
  assign O_v_sync   = r_meas.v_sync;
  assign O_v_bporch = r_meas.v_bporch;
  assign O_v_res    = r_meas.v_res;

endmodule

// File: tb/tb_video_timing_detect.sv
// -----------------------------------------------------------------------------
// tb_video_timing_detect
//   Directed bench for video_timing_detect. Two compact video formats keep the
//   run short: format A plays the role of the first mode, format B the second.
// -----------------------------------------------------------------------------
module tb_video_timing_detect;

  localparam int CW      = 12;
  localparam int TIMEOUT = 4096;

  typedef struct {
    int ht, hsw, hbp, hr, vt, vsw, vbp, vr;
  } fmt_t;

  typedef struct {
    int fmt;       // format sent in this frame
    int bad_line;  // line with one DE pixel missing, -1 for none
    int exp_mv;    // meas_valid pulses expected at this frame's start
    int exp_lock;  // O_locked after this frame's start
    int exp_vals;  // format expected on the measurement outputs (0 = zeros)
  } step_t;

  logic          clk = 1'b0;
  logic          tb_rst, tb_de, tb_hs, tb_vs;
  logic [CW-1:0] h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res;
  logic          meas_valid, locked, o_de;
  logic [CW-1:0] o_x, o_y;

  int n_checks = 0;
  int n_fail   = 0;

  fmt_t  fmts[3];
  step_t steps[13];

  // Monitor state, reset at the start of each frame
  int pix_idx, mv_cnt, mv_pos, coord_err;
  int first_seen, first_x, first_y, last_x, last_y;
  // Expected O_de/O_x/O_y pipeline (two stages)
  logic e_de[2];
  int   e_x[2], e_y[2];

  video_timing_detect #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .I_pxl_clk    (clk),
    .I_rst        (tb_rst),
    .I_de         (tb_de),
    .I_hs         (tb_hs),
    .I_vs         (tb_vs),
    .O_h_total    (h_total),
    .O_h_sync     (h_sync),
    .O_h_bporch   (h_bporch),
    .O_h_res      (h_res),
    .O_v_total    (v_total),
    .O_v_sync     (v_sync),
    .O_v_bporch   (v_bporch),
    .O_v_res      (v_res),
    .O_meas_valid (meas_valid),
    .O_locked     (locked),
    .O_de         (o_de),
    .O_x          (o_x),
    .O_y          (o_y)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One pixel clock: sample outputs first, then drive the next inputs
  task automatic pix(input logic d, input logic h, input logic v, input int x, input int y);
    @(posedge clk);
    #1;
    if (meas_valid === 1'b1) begin
      mv_cnt++;
      mv_pos = pix_idx;
    end
    if (o_de !== e_de[1]) coord_err++;
    else if (e_de[1] && (int'(o_x) != e_x[1] || int'(o_y) != e_y[1])) coord_err++;
    if (o_de === 1'b1) begin
      if (first_seen == 0) begin
        first_seen = 1;
        first_x    = int'(o_x);
        first_y    = int'(o_y);
      end
      last_x = int'(o_x);
      last_y = int'(o_y);
    end
    e_de[1] = e_de[0]; e_x[1] = e_x[0]; e_y[1] = e_y[0];
    e_de[0] = d;       e_x[0] = x;       e_y[0] = y;
    tb_de = d; tb_hs = h; tb_vs = v;
    pix_idx++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      e_de[i] = 1'b0; e_x[i] = 0; e_y[i] = 0;
    end
  endtask

  task automatic send_frame(input fmt_t f, input int bad_line, input int n_lines);
    int hstart, vstart, hend;
    logic d;
    pix_idx = 0; mv_cnt = 0; mv_pos = -1; coord_err = 0; first_seen = 0;
    hstart = f.hsw + f.hbp;
    vstart = f.vsw + f.vbp;
    for (int l = 0; l < n_lines; l++) begin
      hend = hstart + f.hr - ((l == bad_line) ? 1 : 0);
      for (int p = 0; p < f.ht; p++) begin
        d = (l >= vstart) && (l < vstart + f.vr) && (p >= hstart) && (p < hend);
        pix(d, p < f.hsw, l < f.vsw, p - hstart, l - vstart);
      end
    end
  endtask

  task automatic check_vals(input string tag, input fmt_t f);
    check({tag, " h_total"},  h_total,  f.ht);
    check({tag, " h_sync"},   h_sync,   f.hsw);
    check({tag, " h_bporch"}, h_bporch, f.hbp);
    check({tag, " h_res"},    h_res,    f.hr);
    check({tag, " v_total"},  v_total,  f.vt);
    check({tag, " v_sync"},   v_sync,   f.vsw);
    check({tag, " v_bporch"}, v_bporch, f.vbp);
    check({tag, " v_res"},    v_res,    f.vr);
  endtask

  task automatic check_zero(input string tag);
    check_vals(tag, fmts[0]);
    check({tag, " meas_valid"}, meas_valid, 0);
    check({tag, " locked"},     locked,     0);
    check({tag, " o_de"},       o_de,       0);
    check({tag, " o_x"},        o_x,        0);
    check({tag, " o_y"},        o_y,        0);
  endtask

  task automatic run_step(input string tag, input step_t s);
    send_frame(fmts[s.fmt], s.bad_line, fmts[s.fmt].vt);
    check({tag, " meas_valid pulses"}, mv_cnt, s.exp_mv);
    if (s.exp_mv != 0) check({tag, " meas_valid position"}, mv_pos, 2);
    check({tag, " locked"}, locked, s.exp_lock);
    check_vals(tag, fmts[s.exp_vals]);
    check({tag, " coordinate errors"}, coord_err, 0);
  endtask

  initial begin
    fmts[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
    fmts[1] = '{40, 4, 6, 24, 12, 2, 3, 6};   // format A
    fmts[2] = '{52, 5, 9, 32, 15, 3, 2, 8};   // format B

    //          fmt bad  mv lock vals
    steps[0]  = '{1, -1, 0, 0, 0};  // frame start 1: SEARCH -> FIRST
    steps[1]  = '{1, -1, 1, 0, 1};  // frame start 2: reference stored
    steps[2]  = '{1, -1, 1, 1, 1};  // frame start 3: locked
    steps[3]  = '{2, -1, 1, 1, 1};  // closes last A frame
    steps[4]  = '{2, -1, 1, 0, 2};  // first B frame closes: differs
    steps[5]  = '{2, -1, 1, 1, 2};  // relocked on B
    steps[6]  = '{1, -1, 1, 1, 2};  // closes last B frame
    steps[7]  = '{1, -1, 1, 0, 1};  // first A frame closes: differs
    steps[8]  = '{1, -1, 1, 1, 1};
    steps[9]  = '{1,  6, 1, 1, 1};  // this frame has a short DE line
    steps[10] = '{1, -1, 0, 0, 1};  // bad frame closes: back to FIRST
    steps[11] = '{1, -1, 1, 0, 1};  // FIRST -> TRACK
    steps[12] = '{1, -1, 1, 1, 1};  // lock regained

    tb_rst = 1'b1; tb_de = 1'b0; tb_hs = 1'b0; tb_vs = 1'b0;
    clear_model();
    pix_idx = 0; mv_cnt = 0; mv_pos = -1; coord_err = 0; first_seen = 0;
    repeat (3) pix(1'b0, 1'b0, 1'b0, 0, 0);
    check_zero("reset");
    tb_rst = 1'b0;

    for (int i = 0; i < 13; i++) run_step($sformatf("step%0d", i), steps[i]);

    // Coordinates of the last locked frame
    check("first pixel seen", first_seen, 1);
    check("first pixel x", first_x, 0);
    check("first pixel y", first_y, 0);
    check("last pixel x", last_x, fmts[1].hr - 1);
    check("last pixel y", last_y, fmts[1].vr - 1);

    // HS stops while locked
    mv_cnt = 0;
    pix(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 1; i <= TIMEOUT + 8; i++) begin
      pix(1'b0, 1'b0, 1'b0, 0, 0);
      if (i == TIMEOUT - 8) check("timeout locked before expiry", locked, 1);
    end
    check("timeout locked after expiry", locked, 0);
    check("timeout meas_valid pulses", mv_cnt, 0);
    check_vals("timeout held", fmts[1]);

    // Back in SEARCH: three frame starts to relock, values held meanwhile
    run_step("post-timeout 1", '{1, -1, 0, 0, 1});
    run_step("post-timeout 2", '{1, -1, 1, 0, 1});
    run_step("post-timeout 3", '{1, -1, 1, 1, 1});

    // Reset in the middle of a frame (inside the active area)
    send_frame(fmts[1], -1, 7);
    tb_rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("mid-frame reset");
    tb_rst = 1'b0; tb_de = 1'b0; tb_hs = 1'b0; tb_vs = 1'b0;
    clear_model();
    run_step("post-reset 1", '{1, -1, 0, 0, 0});
    run_step("post-reset 2", '{1, -1, 1, 0, 1});
    run_step("post-reset 3", '{1, -1, 1, 1, 1});
    check("post-reset last pixel x", last_x, fmts[1].hr - 1);
    check("post-reset last pixel y", last_y, fmts[1].vr - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_detect.md
Name: video_timing_detect

Overview:
Receive-side counterpart of the HDMI test-pattern timing generator. Samples incoming DE/HS/VS (active-high), measures the full horizontal and vertical timing (total, sync, back porch, resolution) and reports a lock once two consecutive frames match. Also emits per-pixel active-area coordinates so downstream pattern checkers and capture logic can index the incoming video.

Parameters:
CW, 12, width of all timing counters and measurement outputs
TIMEOUT, 4096, pixel clocks without an HS rising edge before lock is dropped

Ports:
I_pxl_clk  in  1  pixel clock; sole clock
I_rst  in  1  synchronous reset, active-high
I_de  in  1  data enable, active-high
I_hs  in  1  horizontal sync, active-high
I_vs  in  1  vertical sync, active-high
O_h_total  out  CW  measured pixels per line
O_h_sync  out  CW  measured HS width
O_h_bporch  out  CW  HS fall to first DE pixel
O_h_res  out  CW  DE pixels per line
O_v_total  out  CW  lines per frame
O_v_sync  out  CW  lines with VS high
O_v_bporch  out  CW  lines from VS end to first DE line
O_v_res  out  CW  lines containing DE
O_meas_valid  out  1  one-cycle pulse when O_h_*/O_v_* update
O_locked  out  1  timing stable over two consecutive frames
O_de  out  1  I_de delayed to align with O_x/O_y
O_x  out  CW  active pixel column, 0 at first DE pixel of line
O_y  out  CW  active line row, 0 at first DE line of frame

Behaviour:
- Reset values: all measurement outputs 0, O_meas_valid 0, O_locked 0, O_de 0, O_x 0, O_y 0; state SEARCH. Reset mid-frame discards all partial measurements.
- Inputs registered once; edges detected from registered vs previous registered value.
- Horizontal position p = samples since the HS rising sample (rising sample p=0). h_sync = p of first HS=0 sample; h_bporch = p of first DE=1 sample minus h_sync; h_res = count of DE=1 samples in line; h_total = p of next HS rising sample.
- Frame start = HS rising sample with VS=1 where VS was 0 at the previous HS rising sample. v_sync = line starts with VS=1; v_bporch = lines after VS low before first line containing DE; v_res = lines containing DE; v_total = line starts between frame starts.
- Within a frame, every DE line must have identical h_sync/h_bporch/h_res and every line identical h_total; any difference, or any counter reaching 2^CW-1, marks the frame bad.
- States: SEARCH -> FIRST on frame start. FIRST -> TRACK at next frame start if frame good (store as reference, outputs updated, O_meas_valid pulses), else stay FIRST. TRACK at each frame start: good frame -> outputs updated, O_meas_valid pulses, O_locked=1 if all eight values equal the previous frame's, else O_locked=0 and reference replaced; bad frame -> O_locked=0, go FIRST.
- Timeout: TIMEOUT cycles without HS rising edge -> O_locked=0, state SEARCH, outputs hold last values.
- O_meas_valid and O_locked update in the cycle after the frame-start sample is registered.
- Coordinates: latency I_de -> O_de exactly 2 clocks. O_x increments per DE pixel, clears after each DE run; O_y increments after each DE line, clears at frame start. Coordinates valid only while O_de=1, independent of lock state.
- DE with HS or VS high is counted as normal DE (no error).

Test Plan:
- 800x600 stream (h 1056/128/88/800, v 628/4/23/600), 3 frames -> O_meas_valid pulses at frame starts 2 and 3; outputs equal those values; O_locked=1 after frame 3 start.
- 1280x720 (1650/40/220/1280, 750/5/20/720) after lock on 800x600 -> first new frame start O_locked=0, values updated; next frame start O_locked=1.
- One line in frame with h_res 799 -> frame bad, O_locked=0, state FIRST; lock regained two good frames later.
- Stop HS for TIMEOUT=4096 cycles while locked -> O_locked falls at cycle 4096; values held.
- Assert I_rst mid-frame -> next clock all outputs 0, SEARCH; lock requires three new frame starts.
- Locked 800x600: first DE pixel of frame -> O_de=1 two clocks later with O_x=0,O_y=0; last active pixel O_x=799,O_y=599.
